// File: rtl/rgb_word_packer.sv
// Packs 24-bit RGB pixels into 32-bit AXI4-Stream words (4 pixels -> 3 words).
// Line ends drive tlast, frame starts drive tuser; partial words are flushed on eol.
module rgb_word_packer (
  input  logic        aclk,
  input  logic        areset,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        valid,
  input  logic        sof,
  input  logic        eol,
  output logic        in_stream_ready,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  output logic        out_stream_tuser,
  output logic        out_stream_tvalid,
  input  logic        out_stream_tready,
  output logic        sync_err
);

  typedef enum logic {IDLE_PACK, FLUSH} state_t;

  state_t      r_state, w_state_nxt;
  logic [23:0] r_acc, w_acc_nxt;
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic [1:0]  r_phase, w_phase_nxt;
  logic [15:0] r_fl_data, w_fl_data_nxt;
  logic [3:0]  r_fl_keep, w_fl_keep_nxt;
  logic        r_sof_pend;
  logic        r_sync_err;
  logic        r_tvalid;
  logic [31:0] r_tdata;
  logic [3:0]  r_tkeep;
  logic        r_tlast;
  logic        r_tuser;

  logic        w_out_free;
  logic        w_ready;
  logic        w_accept;
  logic        w_resync;
  logic [1:0]  w_phase;
  logic        w_load;
  logic [31:0] w_word;
  logic [3:0]  w_keep;
  logic        w_last;

  assign w_out_free = !r_tvalid || out_stream_tready;
  assign w_ready    = !areset && (r_state == IDLE_PACK) && w_out_free;
  assign w_accept   = valid && w_ready;
  // A sof arriving with bytes pending restarts packing at phase 0 with this pixel.
  assign w_resync   = sof && (r_cnt != 2'd0);
  assign w_phase    = w_resync ? 2'd0 : r_phase;

  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_cnt_nxt     = r_cnt;
    w_phase_nxt   = r_phase;
    w_fl_data_nxt = r_fl_data;
    w_fl_keep_nxt = r_fl_keep;
    w_load        = 1'b0;
    w_word        = '0;
    w_keep        = '0;
    w_last        = 1'b0;
    case (r_state)
      IDLE_PACK: begin
        if (w_accept) begin
          case (w_phase)
            2'd0: begin
              if (eol) begin
                w_load      = 1'b1;
                w_word      = {8'h00, b, g, r};
                w_keep      = 4'b0111;
                w_last      = 1'b1;
                w_cnt_nxt   = 2'd0;
                w_phase_nxt = 2'd0;
              end else begin
                w_acc_nxt   = {b, g, r};
                w_cnt_nxt   = 2'd3;
                w_phase_nxt = 2'd1;
              end
            end
            2'd1: begin
              w_load = 1'b1;
              w_word = {r, r_acc};
              w_keep = 4'b1111;
              if (eol) begin
                w_fl_data_nxt = {b, g};
                w_fl_keep_nxt = 4'b0011;
                w_state_nxt   = FLUSH;
                w_cnt_nxt     = 2'd0;
                w_phase_nxt   = 2'd0;
              end else begin
                w_acc_nxt   = {8'h00, b, g};
                w_cnt_nxt   = 2'd2;
                w_phase_nxt = 2'd2;
              end
            end
            2'd2: begin
              w_load = 1'b1;
              w_word = {g, r, r_acc[15:0]};
              w_keep = 4'b1111;
              if (eol) begin
                w_fl_data_nxt = {8'h00, b};
                w_fl_keep_nxt = 4'b0001;
                w_state_nxt   = FLUSH;
                w_cnt_nxt     = 2'd0;
                w_phase_nxt   = 2'd0;
              end else begin
                w_acc_nxt   = {16'h0000, b};
                w_cnt_nxt   = 2'd1;
                w_phase_nxt = 2'd3;
              end
            end
            default: begin
              w_load      = 1'b1;
              w_word      = {b, g, r, r_acc[7:0]};
              w_keep      = 4'b1111;
              w_last      = eol;
              w_cnt_nxt   = 2'd0;
              w_phase_nxt = 2'd0;
            end
          endcase
        end
      end
      FLUSH: begin
        if (w_out_free) begin
          w_load      = 1'b1;
          w_word      = {16'h0000, r_fl_data};
          w_keep      = r_fl_keep;
          w_last      = 1'b1;
          w_state_nxt = IDLE_PACK;
        end
      end
      default: w_state_nxt = IDLE_PACK;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) r_state <= IDLE_PACK;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_phase    <= '0;
      r_fl_data  <= '0;
      r_fl_keep  <= '0;
      r_sof_pend <= 1'b0;
      r_sync_err <= 1'b0;
      r_tvalid   <= 1'b0;
      r_tdata    <= '0;
      r_tkeep    <= '0;
      r_tlast    <= 1'b0;
      r_tuser    <= 1'b0;
    end else begin
      r_acc     <= w_acc_nxt;
      r_cnt     <= w_cnt_nxt;
      r_phase   <= w_phase_nxt;
      r_fl_data <= w_fl_data_nxt;
      r_fl_keep <= w_fl_keep_nxt;
      if (w_accept && w_resync) r_sync_err <= 1'b1;
      // A sof pixel that itself completes a word tags that word directly.
      if (w_load)                r_sof_pend <= 1'b0;
      else if (w_accept && sof)  r_sof_pend <= 1'b1;
      if (w_load) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_word;
        r_tkeep  <= w_keep;
        r_tlast  <= w_last;
        r_tuser  <= r_sof_pend || (w_accept && sof);
      end else if (out_stream_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign in_stream_ready   = w_ready;
  assign out_stream_tdata  = r_tdata;
  assign out_stream_tkeep  = r_tkeep;
  assign out_stream_tlast  = r_tlast;
  assign out_stream_tuser  = r_tuser;
  assign out_stream_tvalid = r_tvalid;
  assign sync_err          = r_sync_err;

endmodule
